// File: rtl/brushless_ctrl.sv
// brushless_ctrl: six-step BLDC commutation with duty ramp.
// Hall sync, IDLE/RUN/BRAKE FSM, fully registered outputs.
module brushless_ctrl #(
   parameter int unsigned RAMP_STEP = 8,
   parameter int unsigned RAMP_DIV  = 4,
   parameter logic [10:0] BRK_DUTY  = 11'h600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        brake_n,
   input  logic [10:0] drv_mag,
   input  logic        hGrn,
   input  logic        hYlw,
   input  logic        hBlu,
   output logic [1:0]  selGrn,
   output logic [1:0]  selYlw,
   output logic [1:0]  selBlu,
   output logic [10:0] duty,
   output logic        running,
   output logic        hall_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BRAKE = 2'd2
   } state_t;

   localparam int unsigned CW   = $clog2(RAMP_DIV);
   localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);
   localparam logic [10:0]   STEP = 11'(RAMP_STEP);

   localparam logic [1:0] HZ  = 2'b00;
   localparam logic [1:0] FWD = 2'b01;
   localparam logic [1:0] REV = 2'b10;
   localparam logic [1:0] BRK = 2'b11;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [10:0]   dint;
   logic [10:0]   dint_nxt;
   logic [10:0]   up_gap;
   logic [10:0]   dn_gap;
   logic [5:0]    comm;
   logic [5:0]    sel_nxt;
   logic [10:0]   duty_nxt;
   logic          run_nxt;
   logic          err_nxt;

   // two-flop synchronizer for the asynchronous hall inputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
      end else begin
         sync1 <= {hGrn, hYlw, hBlu};
         sync2 <= sync1;
      end
   end

   // six-step commutation table; invalid codes float all phases
   always_comb begin
      comm = {HZ, HZ, HZ};
      case (sync2)
         3'b101:  comm = {FWD, REV, HZ};
         3'b100:  comm = {FWD, HZ, REV};
         3'b110:  comm = {HZ, FWD, REV};
         3'b010:  comm = {REV, FWD, HZ};
         3'b011:  comm = {REV, HZ, FWD};
         3'b001:  comm = {HZ, REV, FWD};
         default: comm = {HZ, HZ, HZ};
      endcase
   end

   // ramp divider and duty slew toward drv_mag, clamped at target
   always_comb begin
      cnt_nxt  = '0;
      dint_nxt = '0;
      up_gap   = drv_mag - dint;
      dn_gap   = dint - drv_mag;
      if (state == RUN) begin
         dint_nxt = dint;
         if (cnt == LAST) begin
            cnt_nxt = '0;
            if (dint < drv_mag) begin
               if (up_gap < STEP)
                  dint_nxt = drv_mag;
               else
                  dint_nxt = dint + STEP;
            end else if (dint > drv_mag) begin
               if (dn_gap < STEP)
                  dint_nxt = drv_mag;
               else
                  dint_nxt = dint - STEP;
            end
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   // next state and next output values from the held state
   always_comb begin
      state_nxt = state;
      sel_nxt   = {HZ, HZ, HZ};
      duty_nxt  = '0;
      run_nxt   = 1'b0;
      err_nxt   = 1'b0;
      if (!brake_n) begin
         state_nxt = BRAKE;
      end else begin
         case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            BRAKE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
      case (state)
         RUN: begin
            sel_nxt  = comm;
            duty_nxt = dint_nxt;
            run_nxt  = 1'b1;
            err_nxt  = (sync2 == 3'b000) ||
                       (sync2 == 3'b111);
         end
         BRAKE: begin
            sel_nxt  = {BRK, BRK, BRK};
            duty_nxt = BRK_DUTY;
         end
         default: begin
            sel_nxt  = {HZ, HZ, HZ};
            duty_nxt = '0;
         end
      endcase
   end

   // state, ramp and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         dint     <= '0;
         selGrn   <= HZ;
         selYlw   <= HZ;
         selBlu   <= HZ;
         duty     <= '0;
         running  <= 1'b0;
         hall_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         dint     <= dint_nxt;
         selGrn   <= sel_nxt[5:4];
         selYlw   <= sel_nxt[3:2];
         selBlu   <= sel_nxt[1:0];
         duty     <= duty_nxt;
         running  <= run_nxt;
         hall_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_brushless_ctrl.sv
// tb_brushless_ctrl: scoreboard bench with a cycle-level
// behavioural model, directed scenarios and random stimulus.
module tb_brushless_ctrl;

   localparam int STEP = 8;
   localparam int DIV  = 4;
   localparam int BRKD = 'h600;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        brake_n;
   logic [10:0] drv_mag;
   logic [2:0]  hall;
   logic [1:0]  selGrn;
   logic [1:0]  selYlw;
   logic [1:0]  selBlu;
   logic [10:0] duty;
   logic        running;
   logic        hall_err;

   typedef struct {
      logic [5:0]  sel;
      logic [10:0] duty;
      logic        run;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   tests;
   int   fails;
   bit   stop;

   brushless_ctrl #(
      .RAMP_STEP(STEP),
      .RAMP_DIV(DIV),
      .BRK_DUTY(11'h600)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .brake_n(brake_n),
      .drv_mag(drv_mag),
      .hGrn(hall[2]),
      .hYlw(hall[1]),
      .hBlu(hall[0]),
      .selGrn(selGrn),
      .selYlw(selYlw),
      .selBlu(selBlu),
      .duty(duty),
      .running(running),
      .hall_err(hall_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   // phase pattern for a hall code; invalid codes give all-float
   function automatic logic [5:0] table_sel(input logic [2:0] h);
      case (h)
         3'b101:  return 6'b01_10_00;
         3'b100:  return 6'b01_00_10;
         3'b110:  return 6'b00_01_10;
         3'b010:  return 6'b10_01_00;
         3'b011:  return 6'b10_00_01;
         3'b001:  return 6'b00_10_01;
         default: return 6'b00_00_00;
      endcase
   endfunction

   // reference model: what the outputs must be after each edge
   initial begin
      int st;
      int run_clks;
      int dint;
      int mag;
      logic [2:0] h1;
      logic [2:0] h2;
      exp_t e;
      st = 0;
      run_clks = 0;
      dint = 0;
      h1 = 3'b000;
      h2 = 3'b000;
      forever begin
         @(posedge clk);
         mag = int'(drv_mag);
         e.sel = 6'b0;
         e.duty = 11'd0;
         e.run = 1'b0;
         e.err = 1'b0;
         if (!rst_n) begin
            st = 0;
            run_clks = 0;
            dint = 0;
            h1 = 3'b000;
            h2 = 3'b000;
         end else begin
            if (st == 1) begin
               run_clks++;
               if (run_clks % DIV == 0) begin
                  if (dint < mag)
                     dint += (mag - dint < STEP) ? mag - dint : STEP;
                  else if (dint > mag)
                     dint -= (dint - mag < STEP) ? dint - mag : STEP;
               end
               e.sel = table_sel(h2);
               e.duty = 11'(dint);
               e.run = 1'b1;
               e.err = (h2 == 3'b000) || (h2 == 3'b111);
            end else begin
               run_clks = 0;
               dint = 0;
               if (st == 2) begin
                  e.sel = 6'b11_11_11;
                  e.duty = 11'(BRKD);
               end
            end
            h2 = h1;
            h1 = hall;
            if (!brake_n) st = 2;
            else if (st == 0 && en) st = 1;
            else if (st == 1 && !en) st = 0;
            else if (st == 2) st = 0;
         end
         if (!stop) exp_q.push_back(e);
      end
   end

   // monitor: compare DUT outputs against the queued expectation
   initial begin
      exp_t e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {selGrn, selYlw, selBlu};
            tests++;
            if (act !== e.sel || duty !== e.duty ||
                running !== e.run || hall_err !== e.err) begin
               fails++;
               $display("FAIL cycle t=%0t: got sel=%b duty=%0d run=%b err=%b, want sel=%b duty=%0d run=%b err=%b",
                        $time, act, duty, running, hall_err,
                        e.sel, e.duty, e.run, e.err);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [2:0] seq [6];
      logic [5:0] pat [6];
      int idx;
      seq = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
      pat = '{6'b01_10_00, 6'b01_00_10, 6'b00_01_10,
              6'b10_01_00, 6'b10_00_01, 6'b00_10_01};
      tests = 0;
      fails = 0;
      stop = 0;
      rst_n = 1'b0;
      en = 1'b0;
      brake_n = 1'b1;
      drv_mag = 11'd0;
      hall = 3'b000;
      wait_n(3);
      chk("reset_duty", int'(duty), 0);
      chk("reset_run", int'(running), 0);

      rst_n = 1'b1;
      hall = 3'b101;
      drv_mag = 11'd20;
      wait_n(3);
      chk("idle_no_err", int'(hall_err), 0);
      en = 1'b1;
      wait_n(20);
      chk("ramp_20", int'(duty), 20);
      chk("sel_101", int'({selGrn, selYlw, selBlu}), int'(6'b01_10_00));

      for (int i = 0; i < 6; i++) begin
         hall = seq[i];
         wait_n(5);
         chk("hall_step", int'({selGrn, selYlw, selBlu}), int'(pat[i]));
      end

      hall = 3'b111;
      wait_n(3);
      hall = 3'b101;
      wait_n(6);

      brake_n = 1'b0;
      wait_n(3);
      chk("brake_sel", int'({selGrn, selYlw, selBlu}), 'h3f);
      chk("brake_duty", int'(duty), BRKD);
      brake_n = 1'b1;
      wait_n(25);
      chk("rerun_20", int'(duty), 20);

      drv_mag = 11'd1000;
      wait_n(520);
      chk("ramp_1000", int'(duty), 1000);
      drv_mag = 11'd995;
      wait_n(8);
      chk("ramp_995", int'(duty), 995);
      drv_mag = 11'd2047;
      wait_n(560);
      chk("ramp_2047", int'(duty), 2047);
      drv_mag = 11'd0;
      wait_n(1050);
      chk("ramp_0", int'(duty), 0);

      brake_n = 1'b0;
      wait_n(4);
      rst_n = 1'b0;
      wait_n(1);
      chk("rst_brk_run", int'(running), 0);
      chk("rst_brk_duty", int'(duty), 0);
      chk("rst_brk_sel", int'({selGrn, selYlw, selBlu}), 0);
      wait_n(1);
      rst_n = 1'b1;
      brake_n = 1'b1;

      idx = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         brake_n = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 5) == 0) begin
            idx = (idx + 1) % 6;
            hall = seq[idx];
         end
         if ($urandom_range(0, 49) == 0) hall = 3'($urandom);
         if ($urandom_range(0, 79) == 0) begin
            case ($urandom_range(0, 3))
               0: drv_mag = 11'd0;
               1: drv_mag = 11'd2047;
               default: drv_mag = 11'($urandom);
            endcase
         end
      end

      @(negedge clk);
      stop = 1;
      wait_n(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
